// File: rtl/aes_decryption_if.sv
// Request/response bundle for the AES-128 decryption block.
// master: the requester and result consumer. slave: the decryption core.
interface aes_decryption_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] cipher_in;
    logic [127:0] key;
    logic [127:0] plain_out;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_valid, cipher_in, key, out_ready,
        input  in_ready, plain_out, out_valid
    );

    modport slave (
        input  in_valid, cipher_in, key, out_ready,
        output in_ready, plain_out, out_valid
    );
endinterface

// File: rtl/aes_decryption.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Flow: IDLE -> KEXP (10 forward key-schedule steps) -> INIT (whitening with
// rk10) -> ROUND x10 (round key walked backwards) -> DONE (hold result).
// Optional macro AES_DEC_KEY_CACHE_EN keeps the last key and its rk10 so a
// repeated key skips KEXP.
// S-boxes are built from GF(2^8) inversion plus the affine maps.
module aes_decryption (
    input  logic             clk,
    input  logic             rst,
    aes_decryption_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        INIT  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // GF(2^8) and S-box helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] bb;
        p  = 8'h00;
        x  = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ x;
            x  = xtime(x);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] v;
        v = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(v);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)) ^ Rcon, the non-linear part of the key schedule
    function automatic logic [31:0] g_word(input logic [31:0] w, input logic [7:0] rc);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]) ^ rc, sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    // rk[i] from rk[i-1]
    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ g_word(k[31:0], rc);
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // rk[i-1] from rk[i]; rc is Rcon[i]
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0]   ^ k[63:32];
        p2 = k[63:32]  ^ k[95:64];
        p1 = k[95:64]  ^ k[127:96];
        p0 = k[127:96] ^ g_word(p3, rc);
        return {p0, p1, p2, p3};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         state, state_n;
    logic [3:0]     cnt;
    logic [127:0]   rk;
    logic [127:0]   blk;
    logic [127:0]   cipher_q;
    logic [127:0]   rk_fwd;
    logic [127:0]   rk_bwd;
    logic [127:0]   rk_load;
    logic [127:0]   round_out;
    logic           cache_hit;
    logic           last_round;

    assign rk_fwd     = key_fwd(rk, rcon(cnt + 4'd1));
    assign rk_bwd     = key_inv(rk, rcon((state == INIT) ? 4'd10 : cnt));
    assign last_round = (cnt == 4'd0);

    // ------------------------------------------------------------------
    // Optional key cache: last key and its rk10
    // ------------------------------------------------------------------
`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] key_q;
    logic [127:0] cache_key;
    logic [127:0] cache_rk;
    logic         cache_vld;

    // Record the key on accept and its rk10 when expansion finishes
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q     <= '0;
            cache_key <= '0;
            cache_rk  <= '0;
            cache_vld <= 1'b0;
        end else begin
            if (state == IDLE && bus.in_valid) key_q <= bus.key;
            if (state == KEXP && cnt == 4'd9) begin
                cache_key <= key_q;
                cache_rk  <= rk_fwd;
                cache_vld <= 1'b1;
            end
        end
    end

    assign cache_hit = cache_vld && (bus.key == cache_key);
    assign rk_load   = cache_hit ? cache_rk : bus.key;
`else
    assign cache_hit = 1'b0;
    assign rk_load   = bus.key;
`endif

    // ------------------------------------------------------------------
    // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
    // Byte n of a block sits at bits [127-8n -: 8], row n%4, column n/4.
    // ------------------------------------------------------------------
    logic [7:0] isr_b [16];
    logic [7:0] isb_b [16];
    logic [7:0] ark_b [16];
    logic [7:0] mix_b [16];

    for (genvar n = 0; n < 16; n++) begin : g_byte
        localparam int R   = n % 4;
        localparam int C   = n / 4;
        localparam int SRC = 4 * ((C - R + 4) % 4) + R;
        assign isr_b[n] = blk[127-8*SRC -: 8];
        assign isb_b[n] = inv_sbox(isr_b[n]);
        assign ark_b[n] = isb_b[n] ^ rk[127-8*n -: 8];
        assign round_out[127-8*n -: 8] = last_round ? ark_b[n] : mix_b[n];
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark_b[4*c+0];
        assign a1 = ark_b[4*c+1];
        assign a2 = ark_b[4*c+2];
        assign a3 = ark_b[4*c+3];
        assign mix_b[4*c+0] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        assign mix_b[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        assign mix_b[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        assign mix_b[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state: cache hit jumps straight to INIT
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.in_valid) state_n = cache_hit ? INIT : KEXP;
            KEXP:    if (cnt == 4'd9) state_n = INIT;
            INIT:    state_n = ROUND;
            ROUND:   if (last_round) state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.in_ready = (state == IDLE);
    end

    // Datapath registers: latch, expand, whiten, iterate, hold
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= 4'd0;
            rk            <= '0;
            blk           <= '0;
            cipher_q      <= '0;
            bus.plain_out <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cipher_q <= bus.cipher_in;
                        rk       <= rk_load;
                        cnt      <= 4'd0;
                    end
                end
                KEXP: begin
                    rk  <= rk_fwd;
                    cnt <= cnt + 4'd1;
                end
                INIT: begin
                    blk <= cipher_q ^ rk;
                    rk  <= rk_bwd;
                    cnt <= 4'd9;
                end
                ROUND: begin
                    blk <= round_out;
                    if (last_round) begin
                        bus.plain_out <= round_out;
                        bus.out_valid <= 1'b1;
                    end else begin
                        rk  <= rk_bwd;
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) bus.out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decryption.sv
// Self-checking bench for aes_decryption: FIPS-197 vectors, backpressure,
// mid-operation reset, input noise during processing and random blocks
// checked against a table-driven AES-128 decryption model.
module tb_aes_decryption;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_decryption_if bus();

    aes_decryption dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    // ---------------- reference model ----------------
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        int p, x;
        p = 0;
        x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (((int'(b) >> i) & 1) == 1) p = p ^ x;
            x = x << 1;
            if (x > 255) x = (x ^ 'h11b);
        end
        return 8'(p);
    endfunction

    function automatic int rot8(input int v, input int k);
        return ((v << k) | (v >> (8 - k))) & 'hff;
    endfunction

    task automatic build_tables();
        int inv, s;
        for (int i = 0; i < 256; i++) begin
            inv = 0;
            for (int j = 1; j < 256; j++)
                if (mul(8'(i), 8'(j)) == 8'h01) inv = j;
            s = inv ^ rot8(inv, 1) ^ rot8(inv, 2) ^ rot8(inv, 3) ^ rot8(inv, 4) ^ 'h63;
            sb[i] = 8'(s);
        end
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] ct);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [7:0]   coef [4];
        logic [7:0]   rc, acc;
        logic [31:0]  tmp;
        logic [127:0] out;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = 32'(k >> (96 - 32 * i));
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]] ^ rc, sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                rc  = mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = 8'(ct >> (120 - 8 * n));
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[4*c+r] = s[4*c+r] ^ 8'(w[40+c] >> (24 - 8 * r));
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*((c+r)%4)+r] = s[4*c+r];
            for (int n = 0; n < 16; n++) s[n] = isb[t[n]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = s[4*c+r] ^ 8'(w[4*rnd+c] >> (24 - 8 * r));
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
                    for (int r = 0; r < 4; r++) begin
                        acc = 8'h00;
                        for (int q = 0; q < 4; q++) acc = acc ^ mul(coef[(q-r+4)%4], a[q]);
                        s[4*c+r] = acc;
                    end
                end
            end
        end
        out = '0;
        for (int n = 0; n < 16; n++) out = (out << 8) | 128'(s[n]);
        return out;
    endfunction

    // Expected key-cache behaviour
    bit           cache_v = 1'b0;
    logic [127:0] cache_k = '0;

    function automatic int expect_lat(input logic [127:0] k);
`ifdef AES_DEC_KEY_CACHE_EN
        return (cache_v && k == cache_k) ? 11 : 21;
`else
        return (k === k) ? 21 : 21;
`endif
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One request: accept, measure latency, optional backpressure, release
    task automatic do_req(input string tag, input logic [127:0] k, input logic [127:0] ct,
                          input logic [127:0] exp, input int bp, input bit noise);
        int lat, elat;
        logic [127:0] held;
        elat = expect_lat(k);
        for (int i = 0; i < 50 && !bus.in_ready; i++) step();
        check({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
        bus.in_valid  = 1'b1;
        bus.key       = k;
        bus.cipher_in = ct;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (noise) begin
                bus.in_valid  = 1'($urandom);
                bus.key       = rnd128();
                bus.cipher_in = rnd128();
                bus.out_ready = 1'($urandom);
            end
            step();
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        bus.out_ready = 1'b0;
        check({tag, "_latency"}, 128'(lat), 128'(elat));
        check({tag, "_plain"}, bus.plain_out, exp);
        held = exp;
        for (int b = 0; b < bp; b++) begin
            bus.in_valid  = 1'b1;
            bus.key       = rnd128();
            bus.cipher_in = rnd128();
            step();
            check({tag, "_bp_valid"}, 128'(bus.out_valid), 128'(1));
            check({tag, "_bp_plain"}, bus.plain_out, held);
            check({tag, "_bp_in_ready"}, 128'(bus.in_ready), 128'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_rel_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_rel_in_ready"}, 128'(bus.in_ready), 128'(1));
        cache_v = 1'b1;
        cache_k = k;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [127:0] k, ct, prev_k;
        bit saw;

        build_tables();
        bus.in_valid  = 1'b0;
        bus.key       = '0;
        bus.cipher_in = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        check("reset_in_ready",  128'(bus.in_ready),  128'(1));
        check("reset_out_valid", 128'(bus.out_valid), 128'(0));
        check("reset_plain",     bus.plain_out,       '0);

        // out_ready with nothing pending does nothing
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("idle_oready_valid",    128'(bus.out_valid), 128'(0));
        check("idle_oready_in_ready", 128'(bus.in_ready),  128'(1));

        check("model_appB", model_dec(KEY_B, CT_B), PT_B);
        check("model_appC", model_dec(KEY_C, CT_C), PT_C);

        do_req("appB",     KEY_B, CT_B, PT_B, 0, 1'b0);
        do_req("appB_rep", KEY_B, CT_B, PT_B, 5, 1'b0);
        do_req("appC",     KEY_C, CT_C, PT_C, 0, 1'b1);

        // Reset eight clocks into an App. B request
        bus.in_valid  = 1'b1;
        bus.key       = KEY_B;
        bus.cipher_in = CT_B;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cache_v = 1'b0;
        check("midrst_in_ready",  128'(bus.in_ready),  128'(1));
        check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        check("midrst_plain",     bus.plain_out,       '0);
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.out_valid) saw = 1'b1;
        end
        check("midrst_no_result", 128'(saw), 128'(0));
        do_req("appC_after_rst", KEY_C, CT_C, PT_C, 0, 1'b0);

        // Random blocks, occasionally reusing the previous key
        prev_k = KEY_C;
        for (int i = 0; i < 8; i++) begin
            k  = ($urandom_range(0, 2) == 0) ? prev_k : rnd128();
            ct = rnd128();
            do_req($sformatf("rand%0d", i), k, ct, model_dec(k, ct), i % 3, 1'(i % 2));
            prev_k = k;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
